// File: rtl/flash_burst_responder.sv
// Avalon-MM burst slave that replays page bursts as single-word flash accesses.
// Optional FLASH_BURST_RESPONDER_PAGE_WRAP_EN: addresses wrap inside 256-byte pages.
module flash_burst_responder #(
  parameter int FLASH_ADDR_WIDTH = 28,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [FLASH_ADDR_WIDTH-1:0] avmm_slv_addr,
  input  logic                        avmm_slv_write,
  input  logic                        avmm_slv_read,
  input  logic [6:0]                  avmm_slv_burstcnt,
  input  logic [31:0]                 avmm_slv_wrdata,
  output logic [31:0]                 avmm_slv_rddata,
  output logic                        avmm_slv_rddvld,
  output logic                        avmm_slv_waitreq,
  output logic [FLASH_ADDR_WIDTH-1:0] mem_addr,
  output logic                        mem_write,
  output logic                        mem_read,
  output logic [31:0]                 mem_wrdata,
  input  logic [31:0]                 mem_rddata,
  input  logic                        mem_rddvld,
  input  logic                        mem_waitreq,
  output logic                        burst_err,
  input  logic                        err_clr,
  output logic                        busy,
  output logic [2:0]                  dbg_state
);

  // Handshakes: a slave beat transfers when (read|write) && !avmm_slv_waitreq;
  // a memory request transfers when (mem_read|mem_write) && !mem_waitreq.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BEAT  = 3'd1,
    WR_ISSUE = 3'd2,
    RD_ISSUE = 3'd3,
    RD_DRAIN = 3'd4,
    ERR_RSP  = 3'd5
  } state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t                      state, state_d;
  logic [FLASH_ADDR_WIDTH-1:0] addr_d;
  logic [31:0]                 wrdata_d, rddata_d;
  logic                        rddvld_d, waitreq_d, mem_write_d, mem_read_d;
  logic [6:0]                  remaining, remaining_d, issued, issued_d;
  logic [3:0]                  outstanding, outstanding_d;
  logic                        err_set;

  logic [FLASH_ADDR_WIDTH-1:0] base;
  logic                        cnt_legal, accept, page_over, issue_hs, in_rd, ret_ok;
  logic                        unused_addr_bits;

  assign base      = {avmm_slv_addr[FLASH_ADDR_WIDTH-1:2], 2'b00};
  assign cnt_legal = (avmm_slv_burstcnt != 7'd0) && (avmm_slv_burstcnt <= 7'd64);
  assign accept    = (avmm_slv_write || avmm_slv_read) && !avmm_slv_waitreq;
  assign issue_hs  = mem_read && !mem_waitreq;
  assign in_rd     = (state == RD_ISSUE) || (state == RD_DRAIN);
  // A return with nothing in flight cannot belong to the current burst.
  assign ret_ok    = mem_rddvld && in_rd && (outstanding != 4'd0);
  assign unused_addr_bits = ^avmm_slv_addr[1:0];

`ifdef FLASH_BURST_RESPONDER_PAGE_WRAP_EN
  assign page_over = ({2'b00, avmm_slv_addr[7:2]} + {1'b0, avmm_slv_burstcnt}) > 8'd64;

  function automatic logic [FLASH_ADDR_WIDTH-1:0] next_addr(input logic [FLASH_ADDR_WIDTH-1:0] a);
    logic [5:0] word;
    word = a[7:2] + 6'd1;
    return {a[FLASH_ADDR_WIDTH-1:8], word, 2'b00};
  endfunction
`else
  assign page_over = 1'b0;

  function automatic logic [FLASH_ADDR_WIDTH-1:0] next_addr(input logic [FLASH_ADDR_WIDTH-1:0] a);
    return a + FLASH_ADDR_WIDTH'(4);
  endfunction
`endif

  always_comb begin
    outstanding_d = outstanding;
    case ({issue_hs, ret_ok})
      2'b10:   outstanding_d = outstanding + 4'd1;
      2'b01:   outstanding_d = outstanding - 4'd1;
      default: outstanding_d = outstanding;
    endcase
  end

  always_comb begin
    state_d     = state;
    addr_d      = mem_addr;
    wrdata_d    = mem_wrdata;
    remaining_d = remaining;
    issued_d    = issued;
    rddata_d    = avmm_slv_rddata;
    rddvld_d    = 1'b0;
    err_set     = mem_rddvld && !ret_ok;

    if (ret_ok) begin
      rddata_d = mem_rddata;
      rddvld_d = 1'b1;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          if (avmm_slv_write) begin
            if (!cnt_legal) begin
              err_set = 1'b1;
            end else begin
              addr_d      = base;
              remaining_d = avmm_slv_burstcnt;
              err_set     = err_set || page_over || avmm_slv_read;
              // A read+write command beat carries no usable write data.
              if (avmm_slv_read) begin
                state_d = WR_BEAT;
              end else begin
                wrdata_d = avmm_slv_wrdata;
                state_d  = WR_ISSUE;
              end
            end
          end else if (!cnt_legal) begin
            err_set = 1'b1;
            state_d = ERR_RSP;
          end else begin
            addr_d      = base;
            remaining_d = avmm_slv_burstcnt;
            issued_d    = 7'd0;
            err_set     = err_set || page_over;
            state_d     = RD_ISSUE;
          end
        end
      end
      WR_BEAT: begin
        if (avmm_slv_write && !avmm_slv_waitreq) begin
          wrdata_d = avmm_slv_wrdata;
          state_d  = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (!mem_waitreq) begin
          addr_d      = next_addr(mem_addr);
          remaining_d = remaining - 7'd1;
          state_d     = (remaining == 7'd1) ? IDLE : WR_BEAT;
        end
      end
      RD_ISSUE: begin
        if (issue_hs) begin
          addr_d   = next_addr(mem_addr);
          issued_d = issued + 7'd1;
          if (issued_d == remaining) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        // Waiting one extra cycle lets the last forwarded beat leave first.
        if (outstanding == 4'd0) state_d = IDLE;
      end
      ERR_RSP: begin
        rddata_d = 32'hDEADBEEF;
        rddvld_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    mem_write_d = (state_d == WR_ISSUE);
    mem_read_d  = (state_d == RD_ISSUE) && (issued_d < remaining_d) && (outstanding_d < MAX_OUT);
    waitreq_d   = !((state_d == IDLE) || (state_d == WR_BEAT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      mem_addr         <= '0;
      mem_wrdata       <= '0;
      mem_write        <= 1'b0;
      mem_read         <= 1'b0;
      remaining        <= '0;
      issued           <= '0;
      outstanding      <= '0;
      avmm_slv_rddata  <= '0;
      avmm_slv_rddvld  <= 1'b0;
      avmm_slv_waitreq <= 1'b1;
      burst_err        <= 1'b0;
    end else begin
      state            <= state_d;
      mem_addr         <= addr_d;
      mem_wrdata       <= wrdata_d;
      mem_write        <= mem_write_d;
      mem_read         <= mem_read_d;
      remaining        <= remaining_d;
      issued           <= issued_d;
      outstanding      <= outstanding_d;
      avmm_slv_rddata  <= rddata_d;
      avmm_slv_rddvld  <= rddvld_d;
      avmm_slv_waitreq <= waitreq_d;
      if (err_set)      burst_err <= 1'b1;
      else if (err_clr) burst_err <= 1'b0;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_flash_burst_responder.sv
// Directed bench for flash_burst_responder: burst table plus hand-timed corner sequences.
module tb_flash_burst_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] avmm_slv_addr;
  logic        avmm_slv_write, avmm_slv_read;
  logic [6:0]  avmm_slv_burstcnt;
  logic [31:0] avmm_slv_wrdata, avmm_slv_rddata;
  logic        avmm_slv_rddvld, avmm_slv_waitreq;
  logic [27:0] mem_addr;
  logic        mem_write, mem_read;
  logic [31:0] mem_wrdata, mem_rddata;
  logic        mem_rddvld, mem_waitreq;
  logic        burst_err, err_clr, busy;
  logic [2:0]  dbg_state;

  flash_burst_responder dut (
    .clk(clk), .reset(reset),
    .avmm_slv_addr(avmm_slv_addr), .avmm_slv_write(avmm_slv_write),
    .avmm_slv_read(avmm_slv_read), .avmm_slv_burstcnt(avmm_slv_burstcnt),
    .avmm_slv_wrdata(avmm_slv_wrdata), .avmm_slv_rddata(avmm_slv_rddata),
    .avmm_slv_rddvld(avmm_slv_rddvld), .avmm_slv_waitreq(avmm_slv_waitreq),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
    .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata), .mem_rddvld(mem_rddvld),
    .mem_waitreq(mem_waitreq), .burst_err(burst_err), .err_clr(err_clr),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model / monitor ----------------
  int          cyc = 0;
  int          mem_lat = 1;
  int          stall_left = 0;
  int          inflight = 0;
  int          max_inflight = 0;
  logic        stray_req = 1'b0;
  int          pend_due[$];
  logic [31:0] pend_data[$];
  logic [27:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [27:0] rd_addr_q[$];

  initial begin
    mem_waitreq = 1'b0;
    mem_rddvld  = 1'b0;
    mem_rddata  = 32'h0;
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pend_due.delete();
      pend_data.delete();
      inflight    = 0;
      mem_rddvld  = 1'b0;
      mem_waitreq = 1'b0;
    end else begin
      if (mem_write && stall_left > 0) begin
        mem_waitreq = 1'b1;
        stall_left--;
      end else begin
        mem_waitreq = 1'b0;
      end
      if (mem_write && !mem_waitreq) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wrdata);
      end
      if (mem_read && !mem_waitreq) begin
        rd_addr_q.push_back(mem_addr);
        pend_due.push_back(cyc + mem_lat);
        pend_data.push_back({4'hA, mem_addr});
        inflight++;
      end
      mem_rddvld = 1'b0;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mem_rddvld = 1'b1;
        mem_rddata = pend_data.pop_front();
        void'(pend_due.pop_front());
        inflight--;
      end else if (stray_req) begin
        mem_rddvld = 1'b1;
        mem_rddata = 32'h5757_5757;
        stray_req  = 1'b0;
      end
      if (inflight > max_inflight) max_inflight = inflight;
    end
  end

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [27:0] exp_addr(input logic [27:0] base, input int i);
    logic [27:0] b;
    b = {base[27:2], 2'b00};
`ifdef FLASH_BURST_RESPONDER_PAGE_WRAP_EN
    begin
      logic [5:0] w;
      w = b[7:2] + 6'(i);
      return {b[27:8], w, 2'b00};
    end
`else
    return b + 28'(4 * i);
`endif
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic idle_bus();
    avmm_slv_write = 1'b0;
    avmm_slv_read  = 1'b0;
  endtask

  task automatic wr_beat(input logic [27:0] a, input logic [6:0] c, input logic [31:0] d, input logic rd);
    int n;
    avmm_slv_addr = a; avmm_slv_burstcnt = c; avmm_slv_wrdata = d;
    avmm_slv_write = 1'b1; avmm_slv_read = rd;
    n = 0;
    while (avmm_slv_waitreq && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail("wr_beat_accept");
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || avmm_slv_waitreq) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout_fail(name);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic run_write(input logic [27:0] base, input logic [6:0] cnt, input logic [31:0] seed,
                           input logic exp_err);
    wr_addr_q.delete(); wr_data_q.delete(); stall_left = 0;
    for (int i = 0; i < int'(cnt); i++) wr_beat(base, cnt, seed + 32'(i), 1'b0);
    idle_bus();
    wait_idle("wr_idle");
    check("wr_count", 32'(wr_addr_q.size()), 32'(cnt));
    for (int i = 0; i < int'(cnt) && i < wr_addr_q.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), {4'h0, wr_addr_q[i]}, {4'h0, exp_addr(base, i)});
      check($sformatf("wr_data[%0d]", i), wr_data_q[i], seed + 32'(i));
    end
    check("wr_err", {31'h0, burst_err}, {31'h0, exp_err});
    check("wr_busy_after", {31'h0, busy}, 32'h0);
    clear_err();
  endtask

  task automatic run_read(input logic [27:0] base, input logic [6:0] cnt, input int lat,
                          input logic exp_err, input int exp_max);
    int n, got;
    logic [31:0] e;
    mem_lat = lat; max_inflight = 0; rd_addr_q.delete(); exp_q.delete();
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back({4'hA, exp_addr(base, i)});
    avmm_slv_addr = base; avmm_slv_burstcnt = cnt; avmm_slv_read = 1'b1;
    n = 0;
    while (avmm_slv_waitreq && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout_fail("rd_accept");
    @(negedge clk);
    idle_bus();
    got = 0;
    n = 0;
    while (got < int'(cnt) && n < 500) begin
      if (avmm_slv_rddvld) begin
        got++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        check($sformatf("rd_data[%0d]", got - 1), avmm_slv_rddata, e);
        if (got == int'(cnt)) begin
          check("rd_wait_at_last", {31'h0, avmm_slv_waitreq}, 32'h1);
          @(negedge clk);
          check("rd_wait_after_last", {31'h0, avmm_slv_waitreq}, 32'h0);
        end
      end
      if (got < int'(cnt)) begin
        @(negedge clk);
        n++;
      end
    end
    if (n >= 500) timeout_fail("rd_returns");
    check("rd_issue_count", 32'(rd_addr_q.size()), 32'(cnt));
    for (int i = 0; i < int'(cnt) && i < rd_addr_q.size(); i++)
      check($sformatf("rd_addr[%0d]", i), {4'h0, rd_addr_q[i]}, {4'h0, exp_addr(base, i)});
    check("rd_max_inflight", 32'(max_inflight), 32'(exp_max));
    check("rd_err", {31'h0, burst_err}, {31'h0, exp_err});
    check("rd_busy_after", {31'h0, busy}, 32'h0);
    clear_err();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_wr;
    logic [27:0] base;
    logic [6:0]  cnt;
    int          lat;
    logic        exp_err;
    int          exp_max;
  } vec_t;

`ifdef FLASH_BURST_RESPONDER_PAGE_WRAP_EN
  localparam logic WRAP_ERR = 1'b1;
`else
  localparam logic WRAP_ERR = 1'b0;
`endif

  vec_t vecs[0:6];

  initial begin
    int   n;
    logic ok;

    vecs[0] = '{1'b1, 28'h0000100, 7'd64, 0, 1'b0, 0};
    vecs[1] = '{1'b0, 28'h0000040, 7'd10, 3, 1'b0, 3};
    vecs[2] = '{1'b0, 28'h0000400, 7'd7,  8, 1'b0, 4};
    vecs[3] = '{1'b1, 28'h00001F8, 7'd4,  0, WRAP_ERR, 0};
    vecs[4] = '{1'b0, 28'hFFFFFF8, 7'd3,  2, WRAP_ERR, 2};
    vecs[5] = '{1'b1, 28'h0000003, 7'd2,  0, 1'b0, 0};
    vecs[6] = '{1'b0, 28'h0000010, 7'd1,  1, 1'b0, 1};

    // ---- reset values ----
    reset = 1'b1; err_clr = 1'b0;
    avmm_slv_addr = '0; avmm_slv_burstcnt = '0; avmm_slv_wrdata = '0;
    idle_bus();
    repeat (3) @(negedge clk);
    check("rst_waitreq", {31'h0, avmm_slv_waitreq}, 32'h1);
    check("rst_rddvld", {31'h0, avmm_slv_rddvld}, 32'h0);
    check("rst_rddata", avmm_slv_rddata, 32'h0);
    check("rst_mem_wr_rd", {30'h0, mem_write, mem_read}, 32'h0);
    check("rst_mem_addr", {4'h0, mem_addr}, 32'h0);
    check("rst_mem_wrdata", mem_wrdata, 32'h0);
    check("rst_err_busy", {30'h0, burst_err, busy}, 32'h0);
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    reset = 1'b0;
    check("rel_waitreq_hold", {31'h0, avmm_slv_waitreq}, 32'h1);
    @(negedge clk);
    check("rel_waitreq_drop", {31'h0, avmm_slv_waitreq}, 32'h0);

    // ---- burst table ----
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].is_wr)
        run_write(vecs[v].base, vecs[v].cnt, 32'h5000_0000 + 32'(v * 256), vecs[v].exp_err);
      else
        run_read(vecs[v].base, vecs[v].cnt, vecs[v].lat, vecs[v].exp_err, vecs[v].exp_max);
    end

    // ---- read with burstcnt 0: error response at T+2 ----
    rd_addr_q.delete();
    avmm_slv_addr = 28'h500; avmm_slv_burstcnt = 7'd0; avmm_slv_read = 1'b1;
    @(negedge clk);
    idle_bus();
    check("err_t1_rddvld", {31'h0, avmm_slv_rddvld}, 32'h0);
    check("err_t1_flag", {31'h0, burst_err}, 32'h1);
    @(negedge clk);
    check("err_t2_rddvld", {31'h0, avmm_slv_rddvld}, 32'h1);
    check("err_t2_rddata", avmm_slv_rddata, 32'hDEADBEEF);
    @(negedge clk);
    check("err_t3_rddvld", {31'h0, avmm_slv_rddvld}, 32'h0);
    check("err_t3_waitreq", {31'h0, avmm_slv_waitreq}, 32'h0);
    check("err_no_mem_read", 32'(rd_addr_q.size()), 32'h0);
    clear_err();
    check("err_cleared", {31'h0, burst_err}, 32'h0);

    // ---- single write stalled 5 cycles by memory ----
    wr_addr_q.delete(); wr_data_q.delete();
    stall_left = 5;
    avmm_slv_addr = 28'h200; avmm_slv_burstcnt = 7'd1; avmm_slv_wrdata = 32'h1234_5678;
    avmm_slv_write = 1'b1;
    @(negedge clk);
    idle_bus();
    n = 0; ok = 1'b1;
    while (mem_write && n < 20) begin
      if (mem_addr !== 28'h200 || mem_wrdata !== 32'h1234_5678 || avmm_slv_waitreq !== 1'b1) ok = 1'b0;
      n++;
      @(negedge clk);
    end
    check("stall_write_cycles", 32'(n), 32'd6);
    check("stall_stable", {31'h0, ok}, 32'h1);
    check("stall_writes_logged", 32'(wr_addr_q.size()), 32'd1);
    check("stall_done_waitreq", {31'h0, avmm_slv_waitreq}, 32'h0);

    // ---- two-beat write, cycle-exact ----
    avmm_slv_addr = 28'h240; avmm_slv_burstcnt = 7'd2; avmm_slv_wrdata = 32'h11;
    avmm_slv_write = 1'b1;
    @(negedge clk);
    avmm_slv_wrdata = 32'h22;
    check("b2b_t1", {mem_write, avmm_slv_waitreq, mem_wrdata[29:0]}, {2'b11, 30'h11});
    @(negedge clk);
    check("b2b_t2", {30'h0, avmm_slv_waitreq, mem_write}, 32'h0);
    @(negedge clk);
    idle_bus();
    check("b2b_t3", {mem_write, 3'b0, mem_addr}, {1'b1, 3'b0, 28'h244});
    check("b2b_t3_data", mem_wrdata, 32'h22);
    @(negedge clk);
    check("b2b_t4_busy", {31'h0, busy}, 32'h0);

    // ---- read+write command: error, beat dropped, burst continues ----
    wr_addr_q.delete(); wr_data_q.delete();
    avmm_slv_addr = 28'h300; avmm_slv_burstcnt = 7'd2; avmm_slv_wrdata = 32'hBAD0_BAD0;
    avmm_slv_write = 1'b1; avmm_slv_read = 1'b1;
    @(negedge clk);
    check("rw_err", {31'h0, burst_err}, 32'h1);
    check("rw_state", {29'h0, busy, mem_write, avmm_slv_waitreq}, 32'h4);
    wr_beat(28'h300, 7'd2, 32'h0A, 1'b0);
    wr_beat(28'h300, 7'd2, 32'h0B, 1'b0);
    idle_bus();
    wait_idle("rw_idle");
    check("rw_count", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("rw_addr0", {4'h0, wr_addr_q[0]}, 32'h300);
      check("rw_addr1", {4'h0, wr_addr_q[1]}, 32'h304);
      check("rw_data0", wr_data_q[0], 32'h0A);
      check("rw_data1", wr_data_q[1], 32'h0B);
    end
    clear_err();

    // ---- illegal write count with simultaneous err_clr: set wins ----
    wr_addr_q.delete();
    avmm_slv_addr = 28'h600; avmm_slv_burstcnt = 7'd65; avmm_slv_wrdata = 32'h77;
    avmm_slv_write = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    idle_bus(); err_clr = 1'b0;
    check("ill_wr_err", {31'h0, burst_err}, 32'h1);
    check("ill_wr_idle", {29'h0, busy, mem_write, avmm_slv_waitreq}, 32'h0);
    @(negedge clk);
    check("ill_wr_no_mem", 32'(wr_addr_q.size()), 32'h0);
    clear_err();

    // ---- stray memory return while idle ----
    stray_req = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (avmm_slv_rddvld) ok = 1'b0;
    end
    check("stray_dropped", {31'h0, ok}, 32'h1);
    check("stray_err", {31'h0, burst_err}, 32'h1);
    clear_err();

    // ---- reset with two reads outstanding ----
    mem_lat = 6;
    avmm_slv_addr = 28'h800; avmm_slv_burstcnt = 7'd8; avmm_slv_read = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      idle_bus();
      #1;
      n++;
    end while (inflight < 2 && n < 20);
    if (n >= 20) timeout_fail("mid_rd_inflight");
    reset = 1'b1;
    #1;
    check("mid_rst_waitreq", {31'h0, avmm_slv_waitreq}, 32'h1);
    check("mid_rst_rd", {30'h0, avmm_slv_rddvld, mem_read}, 32'h0);
    check("mid_rst_rddata", avmm_slv_rddata, 32'h0);
    check("mid_rst_mem_addr", {4'h0, mem_addr}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_read(28'h0000020, 7'd1, 2, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
